rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one downstream resource among 8 requesters. A registered grant is held until the owner drops its request or a hold timeout expires. Winner selection uses a rotating-mask priority encode over the request vector. The arbiter sits in front of any shared datapath that the encoder-based blocks feed.

---
 rtl/rr_arbiter8_pkg.sv | 10 +
 rtl/rr_arbiter8_if.sv | 11 +
 rtl/rr_mask_encoder8.sv | 19 +
 rtl/rr_arbiter8.sv | 61 ++++++
 tb/tb_rr_arbiter8.sv | 139 +++++++++++++
 5 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rr_arb_pkg: shared state type, id width and rotate helper for the round-robin arbiter
package rr_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int ID_W = 3;
  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [ID_W-1:0] sh);
    logic [15:0] d;
    d = {v, v} >> sh;
    return d[7:0];
  endfunction
endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesters and the arbiter
interface rr_arbiter8_if;
  import rr_arb_pkg::*;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic gnt_valid;
  logic timeout;
  modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
  modport slave (input req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_mask_encoder8.sv
// rr_mask_encoder8: first set request at or after ptr, wrapping mod 8
module rr_mask_encoder8
  import rr_arb_pkg::*;
(
  input  logic [7:0]      req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] idx
);
  logic [7:0] rot;
  logic [ID_W-1:0] lo;
  always_comb begin
    rot = rotr8(req, ptr);
    lo = '0;
    for (int i = 7; i >= 0; i--) lo = rot[i] ? ID_W'(i) : lo;
  end
  assign any = |req;
  assign idx = lo + ptr;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters with registered grant and hold timeout
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  rr_arbiter8_if.slave b
);
  state_t state, state_d;
  logic [ID_W-1:0] ptr, ptr_d, id, id_d, win;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic to, to_d, any, own_req, expire;
  rr_mask_encoder8 u_enc (.req(b.req), .ptr(ptr), .any(any), .idx(win));
  assign own_req = b.req[id];
  assign expire = MAX_HOLD != 0 && cnt == CNT_W'(MAX_HOLD - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      id <= '0;
      cnt <= '0;
      to <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      id <= id_d;
      cnt <= cnt_d;
      to <= to_d;
    end
  end
  // Any release goes through IDLE, giving the mandatory dead cycle before the next grant
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    id_d = id;
    cnt_d = cnt;
    to_d = 1'b0;
    if (state == IDLE) begin
      state_d = any ? GRANT : IDLE;
      id_d = any ? win : id;
      cnt_d = any ? '0 : cnt;
    end else if (!own_req || expire) begin
      state_d = IDLE;
      ptr_d = id + 1'b1;
      to_d = own_req;
    end else begin
      cnt_d = &cnt ? cnt : cnt + 1'b1;
    end
  end
  always_comb begin
    b.gnt = state == GRANT ? 8'(1) << id : 8'h00;
    b.gnt_valid = state == GRANT;
    b.gnt_id = id;
    b.timeout = to;
  end
  assert property (@(posedge clk) disable iff (rst) !$isunknown(b.req));
  assert property (@(posedge clk) disable iff (rst) $onehot0(b.gnt) && !(b.timeout && b.gnt_valid));
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: random and directed stimulus checked against a behavioural arbiter model
module tb_rr_arbiter8;
  localparam int MAXH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  rr_arbiter8_if bus ();
  rr_arbiter8 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;

  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_id = 0;
  bit m_to = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr = 0;
      m_cnt = 0;
      m_id = 0;
      m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < 8; k++)
          if (m_owner < 0 && bus.req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
        if (m_owner >= 0) begin
          m_id = m_owner;
          m_cnt = 0;
        end
      end else if (!bus.req[m_owner] || m_cnt == MAXH - 1) begin
        m_to = bus.req[m_owner];
        m_ptr = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] eg;
    eg = m_owner < 0 ? 8'h00 : 8'(1 << m_owner);
    checks++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout} !== {eg, m_owner >= 0, 3'(m_id), m_to}) begin
      errors++;
      $display("FAIL model t=%0t: gnt=%h valid=%b id=%0d to=%b, expected gnt=%h valid=%b id=%0d to=%b",
               $time, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout, eg, m_owner >= 0, m_id, m_to);
    end
  end

  task automatic lit(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] r;
    bus.req = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(8'h00);
      lit("idle", {bus.gnt, 6'd0, bus.gnt_valid, bus.timeout}, 16'h0000);
    end
    step(8'h04);
    lit("single_gnt", {bus.gnt, 5'd0, bus.gnt_id}, {8'h04, 8'h02});
    step(8'h04);
    step(8'h04);
    lit("single_hold", {8'd0, bus.gnt}, 16'h0004);
    step(8'h00);
    lit("single_drop", {7'd0, bus.gnt_valid, bus.gnt}, 16'h0000);
    step(8'h0C);
    lit("next_from_3", {13'd0, bus.gnt_id}, 16'd3);
    step(8'h00);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(8'hFF);
      lit($sformatf("rot_id%0d", i), {7'd0, bus.gnt_valid, 5'd0, bus.gnt_id}, {8'h01, 8'(i % 8)});
      step(~(8'h01 << (i % 8)));
      lit($sformatf("rot_gap%0d", i), {8'd0, bus.gnt}, 16'h0000);
    end
    step(8'h40);
    lit("wrap_own6", {13'd0, bus.gnt_id}, 16'd6);
    step(8'h00);
    step(8'h81);
    lit("wrap_win7", {13'd0, bus.gnt_id}, 16'd7);
    step(8'h01);
    step(8'h81);
    lit("wrap_win0", {13'd0, bus.gnt_id}, 16'd0);
    step(8'h00);
    for (int i = 0; i < MAXH; i++) begin
      step(8'h10);
      lit($sformatf("hold%0d", i), {7'd0, bus.timeout, bus.gnt}, 16'h0010);
    end
    step(8'h10);
    lit("timeout_pulse", {7'd0, bus.timeout, bus.gnt}, 16'h0100);
    step(8'h10);
    lit("regrant4", {7'd0, bus.timeout, bus.gnt}, 16'h0010);
    repeat (MAXH) step(8'h30);
    lit("timeout2", {15'd0, bus.timeout}, 16'h0001);
    step(8'h30);
    lit("rotate_to5", {13'd0, bus.gnt_id}, 16'd5);
    step(8'h00);
    step(8'h08);
    lit("pre_rst", {8'd0, bus.gnt}, 16'h0008);
    #1 rst = 1'b1;
    #1 lit("async_rst", {bus.gnt, 4'd0, bus.gnt_valid, bus.gnt_id}, 16'h0000);
    rst = 1'b0;
    step(8'h80);
    lit("post_rst7", {bus.gnt, 5'd0, bus.gnt_id}, {8'h80, 8'h07});
    step(8'h00);
    r = 8'h00;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom) & 8'($urandom);
      step(r);
      if ($urandom_range(399) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    step(8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
